// File: rtl/mem_stage.sv
// Memory stage: pass-through for ALU ops, req/ack data-memory access
// with wait states, timeout abort and misalignment trap for loads/stores.
module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ac_pc,
   input  logic [4:0]  ac_write_sel,
   input  logic        ac_is_load,
   input  logic        ac_is_store,
   input  logic        ac_is_wb,
   input  logic [1:0]  ac_size,
   input  logic        ac_unsigned,
   input  logic [31:0] ALU_result,
   input  logic [31:0] ac_store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic [31:0] cw_pc,
   output logic [4:0]  cw_write_sel,
   output logic        cw_is_wb,
   output logic [31:0] cw_result,
   output logic        mem_misaligned,
   output logic        mem_timeout
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               mem_op;
   logic               misaligned;
   logic               timeout_hit;
   logic [3:0]         be_n;
   logic [31:0]        wdata_n;
   logic [31:0]        lane;
   logic [31:0]        load_val;

   always_comb begin
      mem_op      = ac_is_load | ac_is_store;
      misaligned  = 1'b0;
      be_n        = 4'b1111;
      wdata_n     = ac_store_data;
      load_val    = 32'b0;
      timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
      lane        = dmem_rdata >> {ALU_result[1:0], 3'b000};
      case (ac_size)
         2'b00: begin
            be_n     = 4'b0001 << ALU_result[1:0];
            wdata_n  = {4{ac_store_data[7:0]}};
            load_val = ac_unsigned ? {24'b0, lane[7:0]}
                                   : {{24{lane[7]}}, lane[7:0]};
         end
         2'b01: begin
            misaligned = ALU_result[0];
            be_n       = 4'b0011 << ALU_result[1:0];
            wdata_n    = {2{ac_store_data[15:0]}};
            load_val   = ac_unsigned ? {16'b0, lane[15:0]}
                                     : {{16{lane[15]}}, lane[15:0]};
         end
         default: begin
            misaligned = |ALU_result[1:0];
            load_val   = lane;
         end
      endcase
      // in ACCESS, ack or timeout both end the access this cycle
      if (state == IDLE) stall = mem_op & ~misaligned;
      else               stall = ~dmem_ack & ~timeout_hit;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= 32'b0;
         dmem_wdata     <= 32'b0;
         dmem_be        <= 4'b0;
         cw_pc          <= 32'b0;
         cw_write_sel   <= 5'b0;
         cw_is_wb       <= 1'b0;
         cw_result      <= 32'b0;
         mem_misaligned <= 1'b0;
         mem_timeout    <= 1'b0;
      end else begin
         mem_misaligned <= 1'b0;
         mem_timeout    <= 1'b0;
         case (state)
            IDLE: begin
               cw_pc        <= ac_pc;
               cw_write_sel <= ac_write_sel;
               if (!mem_op) begin
                  cw_is_wb  <= ac_is_wb;
                  cw_result <= ALU_result;
               end else if (misaligned) begin
                  cw_is_wb       <= 1'b0;
                  cw_result      <= ALU_result;
                  mem_misaligned <= 1'b1;
               end else begin
                  state      <= ACCESS;
                  cnt        <= '0;
                  dmem_req   <= 1'b1;
                  dmem_we    <= ac_is_store;
                  dmem_addr  <= {ALU_result[31:2], 2'b00};
                  dmem_be    <= be_n;
                  dmem_wdata <= wdata_n;
                  cw_is_wb   <= 1'b0;
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  state        <= IDLE;
                  dmem_req     <= 1'b0;
                  cw_pc        <= ac_pc;
                  cw_write_sel <= ac_write_sel;
                  if (ac_is_load) begin
                     cw_is_wb  <= ac_is_wb;
                     cw_result <= load_val;
                  end else begin
                     cw_is_wb  <= 1'b0;
                     cw_result <= ALU_result;
                  end
               end else if (timeout_hit) begin
                  state        <= IDLE;
                  dmem_req     <= 1'b0;
                  cw_pc        <= ac_pc;
                  cw_write_sel <= ac_write_sel;
                  cw_is_wb     <= 1'b0;
                  mem_timeout  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
